// File: rtl/pwr_seq_pkg.sv
// Shared types and default timing for the power-gating sequencer.
// State encodings stay fixed so legacy debug tooling can decode the state register.
package pwr_seq_pkg;

    localparam int ISO_SETUP_CYC_DEF = 2;
    localparam int SAVE_CYC_DEF      = 1;
    localparam int RST_CYC_DEF       = 2;
    localparam int RESTORE_CYC_DEF   = 1;
    localparam int ISO_HOLD_CYC_DEF  = 2;
    localparam int ACK_TIMEOUT_DEF   = 16;

    localparam logic [3:0] ST_ON        = 4'd0;
    localparam logic [3:0] ST_ISO_SETUP = 4'd1;
    localparam logic [3:0] ST_SAVE      = 4'd2;
    localparam logic [3:0] ST_SW_OFF    = 4'd3;
    localparam logic [3:0] ST_OFF       = 4'd4;
    localparam logic [3:0] ST_SW_ON     = 4'd5;
    localparam logic [3:0] ST_RESET     = 4'd6;
    localparam logic [3:0] ST_RESTORE   = 4'd7;
    localparam logic [3:0] ST_ISO_HOLD  = 4'd8;
    localparam logic [3:0] ST_ERR       = 4'd9;

    typedef enum logic [3:0] {
        S_ON        = ST_ON,
        S_ISO_SETUP = ST_ISO_SETUP,
        S_SAVE      = ST_SAVE,
        S_SW_OFF    = ST_SW_OFF,
        S_OFF       = ST_OFF,
        S_SW_ON     = ST_SW_ON,
        S_RESET     = ST_RESET,
        S_RESTORE   = ST_RESTORE,
        S_ISO_HOLD  = ST_ISO_HOLD,
        S_ERR       = ST_ERR
    } pwr_state_t;

    typedef struct packed {
        logic pwr_en;
        logic iso_enable;
        logic save;
        logic restore;
        logic dom_rst;
        logic busy;
        logic is_off;
        logic err;
    } pwr_out_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic pwr_out_t state_out(input pwr_state_t s);
        pwr_out_t o;
        o = '0;
        case (s)
            S_ON:        begin o.pwr_en = 1'b1; end
            S_ISO_SETUP: begin o.pwr_en = 1'b1; o.iso_enable = 1'b1; o.busy = 1'b1; end
            S_SAVE:      begin o.pwr_en = 1'b1; o.iso_enable = 1'b1; o.save = 1'b1; o.busy = 1'b1; end
            S_SW_OFF:    begin o.iso_enable = 1'b1; o.busy = 1'b1; end
            S_OFF:       begin o.iso_enable = 1'b1; o.dom_rst = 1'b1; o.is_off = 1'b1; end
            S_SW_ON:     begin o.pwr_en = 1'b1; o.iso_enable = 1'b1; o.dom_rst = 1'b1; o.busy = 1'b1; end
            S_RESET:     begin o.pwr_en = 1'b1; o.iso_enable = 1'b1; o.dom_rst = 1'b1; o.busy = 1'b1; end
            S_RESTORE:   begin o.pwr_en = 1'b1; o.iso_enable = 1'b1; o.restore = 1'b1; o.busy = 1'b1; end
            S_ISO_HOLD:  begin o.pwr_en = 1'b1; o.iso_enable = 1'b1; o.busy = 1'b1; end
            S_ERR:       begin o.iso_enable = 1'b1; o.dom_rst = 1'b1; o.err = 1'b1; end
            default:     begin o.pwr_en = 1'b1; end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pwr_seq_ctrl_timer.sv
// Loadable down-counter shared by the timed states and the ack-wait timeout.
module pwr_seq_ctrl_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-gating sequencer: orders isolation, retention, switch and domain reset.
// Outputs are registered from the next-state decode so they always match the state register.
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int ISO_SETUP_CYC = ISO_SETUP_CYC_DEF,
    parameter int SAVE_CYC      = SAVE_CYC_DEF,
    parameter int RST_CYC       = RST_CYC_DEF,
    parameter int RESTORE_CYC   = RESTORE_CYC_DEF,
    parameter int ISO_HOLD_CYC  = ISO_HOLD_CYC_DEF,
    parameter int ACK_TIMEOUT   = ACK_TIMEOUT_DEF,
    parameter int CNT_W         = $clog2(max_of(max_of(max_of(ISO_SETUP_CYC, SAVE_CYC),
                                                       max_of(RST_CYC, RESTORE_CYC)),
                                                max_of(ISO_HOLD_CYC, ACK_TIMEOUT))) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pwr_down_req,
    input  logic pwr_up_req,
    input  logic pwr_ack,
    input  logic err_clr,
    output logic pwr_en,
    output logic iso_enable,
    output logic save,
    output logic restore,
    output logic dom_rst,
    output logic busy,
    output logic is_off,
    output logic err
);

    pwr_state_t       state_q;
    pwr_state_t       state_d;
    pwr_out_t         out_q;
    logic             tmr_load;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ON:        if (pwr_down_req) state_d = S_ISO_SETUP;
            S_ISO_SETUP: if (tmr_zero)     state_d = S_SAVE;
            S_SAVE:      if (tmr_zero)     state_d = S_SW_OFF;
            S_SW_OFF: begin
                if (!pwr_ack)      state_d = S_OFF;
                else if (tmr_zero) state_d = S_ERR;
            end
            S_OFF:       if (pwr_up_req)   state_d = S_SW_ON;
            S_SW_ON: begin
                if (pwr_ack)       state_d = S_RESET;
                else if (tmr_zero) state_d = S_ERR;
            end
            S_RESET:     if (tmr_zero)     state_d = S_RESTORE;
            S_RESTORE:   if (tmr_zero)     state_d = S_ISO_HOLD;
            S_ISO_HOLD:  if (tmr_zero)     state_d = S_ON;
            S_ERR:       if (err_clr)      state_d = S_OFF;
            default:                       state_d = S_ON;
        endcase
    end

    // No state loops back to itself through a transition, so any change marks an entry.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            S_ISO_SETUP: tmr_val = CNT_W'(ISO_SETUP_CYC - 1);
            S_SAVE:      tmr_val = CNT_W'(SAVE_CYC - 1);
            S_SW_OFF:    tmr_val = CNT_W'(ACK_TIMEOUT - 1);
            S_SW_ON:     tmr_val = CNT_W'(ACK_TIMEOUT - 1);
            S_RESET:     tmr_val = CNT_W'(RST_CYC - 1);
            S_RESTORE:   tmr_val = CNT_W'(RESTORE_CYC - 1);
            S_ISO_HOLD:  tmr_val = CNT_W'(ISO_HOLD_CYC - 1);
            default:     tmr_val = '0;
        endcase
    end

    pwr_seq_ctrl_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ON;
            out_q   <= state_out(S_ON);
        end else begin
            state_q <= state_d;
            out_q   <= state_out(state_d);
        end
    end

    assign pwr_en     = out_q.pwr_en;
    assign iso_enable = out_q.iso_enable;
    assign save       = out_q.save;
    assign restore    = out_q.restore;
    assign dom_rst    = out_q.dom_rst;
    assign busy       = out_q.busy;
    assign is_off     = out_q.is_off;
    assign err        = out_q.err;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Scoreboard bench: stimulus queues the expected output vector per cycle, a monitor checks it.
module tb_pwr_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic pwr_down_req, pwr_up_req, pwr_ack, err_clr;
    logic pwr_en, iso_enable, save, restore, dom_rst, busy, is_off, err;

    // Vector order: {pwr_en, iso, save, restore, dom_rst, busy, is_off, err}
    localparam logic [7:0] V_ON   = 8'h80;
    localparam logic [7:0] V_ISU  = 8'hC4;
    localparam logic [7:0] V_SAVE = 8'hE4;
    localparam logic [7:0] V_SWOF = 8'h44;
    localparam logic [7:0] V_OFF  = 8'h4A;
    localparam logic [7:0] V_SWON = 8'hCC;
    localparam logic [7:0] V_RST  = 8'hCC;
    localparam logic [7:0] V_RSTR = 8'hD4;
    localparam logic [7:0] V_ISH  = 8'hC4;
    localparam logic [7:0] V_ERR  = 8'h49;

    typedef struct {
        logic [7:0] v;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pwr_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pwr_down_req (pwr_down_req),
        .pwr_up_req   (pwr_up_req),
        .pwr_ack      (pwr_ack),
        .err_clr      (err_clr),
        .pwr_en       (pwr_en),
        .iso_enable   (iso_enable),
        .save         (save),
        .restore      (restore),
        .dom_rst      (dom_rst),
        .busy         (busy),
        .is_off       (is_off),
        .err          (err)
    );

    wire [7:0] act = {pwr_en, iso_enable, save, restore, dom_rst, busy, is_off, err};

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b at %0t", e.name, act, e.v, $time);
            end
            checks++;
            if ((save && restore) || (!iso_enable && (!pwr_en || dom_rst))) begin
                errors++;
                $display("FAIL invariant(%s): got %b expected save/restore exclusive and iso covering", e.name, act);
            end
        end
    end

    task automatic cyc(input logic d, input logic u, input logic a, input logic c,
                       input logic [7:0] v, input string name);
        exp_t e;
        pwr_down_req = d;
        pwr_up_req   = u;
        pwr_ack      = a;
        err_clr      = c;
        e.v    = v;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        pwr_down_req = 1'b0;
        pwr_up_req   = 1'b0;
        pwr_ack      = 1'b1;
        err_clr      = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 1, 0, V_ON, "reset_state");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, V_ON, "idle");

        // Power-down, ack drops 3 cycles after pwr_en falls
        cyc(1, 0, 1, 0, V_ON,   "pd_req");
        cyc(0, 0, 1, 0, V_ISU,  "pd_iso1");
        cyc(0, 0, 1, 0, V_ISU,  "pd_iso2");
        cyc(0, 0, 1, 0, V_SAVE, "pd_save");
        cyc(0, 0, 1, 0, V_SWOF, "pd_swoff1");
        cyc(0, 0, 1, 0, V_SWOF, "pd_swoff2");
        cyc(0, 0, 1, 0, V_SWOF, "pd_swoff3");
        cyc(0, 0, 0, 0, V_SWOF, "pd_swoff4");
        cyc(0, 0, 0, 0, V_OFF,  "pd_off");
        cyc(0, 0, 0, 1, V_OFF,  "off_clr_ignored");
        cyc(0, 0, 0, 0, V_OFF,  "off_hold");

        // Power-up, ack rises 2 cycles after request
        cyc(0, 1, 0, 0, V_OFF,  "pu_req");
        cyc(0, 0, 0, 0, V_SWON, "pu_swon1");
        cyc(0, 0, 0, 0, V_SWON, "pu_swon2");
        cyc(0, 0, 1, 0, V_SWON, "pu_swon3");
        cyc(0, 0, 1, 0, V_RST,  "pu_rst1");
        cyc(0, 0, 1, 0, V_RST,  "pu_rst2");
        cyc(0, 0, 1, 0, V_RSTR, "pu_restore");
        cyc(0, 0, 1, 0, V_ISH,  "pu_hold1");
        cyc(0, 0, 1, 0, V_ISH,  "pu_hold2");
        cyc(0, 0, 1, 0, V_ON,   "pu_on");

        // Ack stuck at 1: timeout after 16 cycles in SW_OFF
        cyc(1, 0, 1, 0, V_ON,   "to_req");
        cyc(0, 0, 1, 0, V_ISU,  "to_iso1");
        cyc(0, 0, 1, 0, V_ISU,  "to_iso2");
        cyc(0, 0, 1, 0, V_SAVE, "to_save");
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, V_SWOF, "to_swoff");
        cyc(0, 0, 1, 1, V_ERR,  "to_err");
        cyc(0, 0, 1, 0, V_OFF,  "to_clr_off");

        // Power-up with ack already high
        cyc(0, 1, 1, 0, V_OFF,  "pu2_req");
        cyc(0, 0, 1, 0, V_SWON, "pu2_swon");
        cyc(0, 0, 1, 0, V_RST,  "pu2_rst1");
        cyc(0, 0, 1, 0, V_RST,  "pu2_rst2");
        cyc(0, 0, 1, 0, V_RSTR, "pu2_restore");
        cyc(0, 0, 1, 0, V_ISH,  "pu2_hold1");
        cyc(0, 0, 1, 0, V_ISH,  "pu2_hold2");
        cyc(0, 0, 1, 0, V_ON,   "pu2_on");

        // pwr_up_req pulse during ISO_SETUP is ignored
        cyc(1, 0, 1, 0, V_ON,   "ig_req");
        cyc(0, 1, 1, 0, V_ISU,  "ig_iso1");
        cyc(0, 0, 1, 0, V_ISU,  "ig_iso2");
        cyc(0, 0, 1, 0, V_SAVE, "ig_save");
        cyc(0, 0, 0, 0, V_SWOF, "ig_swoff");
        cyc(0, 0, 0, 0, V_OFF,  "ig_off");

        cyc(0, 1, 0, 0, V_OFF,  "pu3_req");
        cyc(0, 0, 1, 0, V_SWON, "pu3_swon");
        cyc(0, 0, 1, 0, V_RST,  "pu3_rst1");
        cyc(0, 0, 1, 0, V_RST,  "pu3_rst2");
        cyc(0, 0, 1, 0, V_RSTR, "pu3_restore");
        cyc(0, 0, 1, 0, V_ISH,  "pu3_hold1");
        cyc(0, 0, 1, 0, V_ISH,  "pu3_hold2");
        cyc(0, 0, 1, 0, V_ON,   "pu3_on");

        // Both requests high in ON acts as power-down
        cyc(1, 1, 1, 0, V_ON,   "both_on");
        cyc(0, 0, 1, 0, V_ISU,  "both_iso1");
        cyc(0, 0, 1, 0, V_ISU,  "both_iso2");
        cyc(0, 0, 1, 0, V_SAVE, "both_save");
        cyc(0, 0, 0, 0, V_SWOF, "both_swoff");
        cyc(0, 0, 0, 0, V_OFF,  "both_off");

        // Both high in OFF acts as power-up; then async reset in RESET
        cyc(1, 1, 0, 0, V_OFF,  "both_off_req");
        cyc(0, 0, 1, 0, V_SWON, "both_swon");
        cyc(0, 0, 1, 0, V_RST,  "both_rst1");
        rst = 1'b1;
        cyc(0, 0, 1, 0, V_ON,   "async_rst");
        cyc(0, 0, 1, 0, V_ON,   "rst_held");
        rst = 1'b0;
        cyc(0, 0, 1, 0, V_ON,   "post_rst1");
        cyc(0, 0, 1, 0, V_ON,   "post_rst2");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
